// File: rtl/udp_port_filter.sv
// Filters an upstream UDP beat stream down to one destination port and a payload length window,
// forwarding admitted packets through a single-entry output register and counting the decisions.
module udp_port_filter #(
  parameter logic [15:0] LISTEN_PORT = 16'd6000,
  parameter logic [15:0] MIN_LEN     = 16'd4,
  parameter logic [15:0] MAX_LEN     = 16'd1472
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        udp_source_valid,
  input  logic        udp_source_last,
  output logic        udp_source_ready,
  input  logic [15:0] udp_source_src_port,
  input  logic [15:0] udp_source_dst_port,
  input  logic [31:0] udp_source_ip_address,
  input  logic [15:0] udp_source_length,
  input  logic [31:0] udp_source_data,
  input  logic [3:0]  udp_source_error,
  output logic        udp_out_valid,
  output logic        udp_out_last,
  input  logic        udp_out_ready,
  output logic [15:0] udp_out_src_port,
  output logic [15:0] udp_out_dst_port,
  output logic [31:0] udp_out_ip_address,
  output logic [15:0] udp_out_length,
  output logic [31:0] udp_out_data,
  output logic [3:0]  udp_out_error,
  input  logic        enable,
  input  logic        stats_clear,
  output logic [15:0] accept_count,
  output logic [15:0] drop_count,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1, DROP = 2'd2} state_t;

  state_t state;
  logic   src_xfer;
  logic   out_xfer;
  logic   match;
  logic   first_xfer;
  logic   load;

  assign fsm_state = state;

  // Handshake: a beat moves when valid && ready on the same rising edge; valid never waits on ready.
  // DROP swallows beats regardless of the output side; otherwise the output register must be free
  // or draining this cycle.
  always_comb begin
    udp_source_ready = 1'b0;
    if (!reset) begin
      if (state == DROP) udp_source_ready = 1'b1;
      else               udp_source_ready = !udp_out_valid || udp_out_ready;
    end
  end

  assign src_xfer   = udp_source_valid && udp_source_ready;
  assign out_xfer   = udp_out_valid && udp_out_ready;
  assign match      = enable && (udp_source_dst_port == LISTEN_PORT) &&
                      (udp_source_length >= MIN_LEN) && (udp_source_length <= MAX_LEN) &&
                      (udp_source_error == 4'h0);
  assign first_xfer = src_xfer && (state == IDLE);
  assign load       = src_xfer && ((state == PASS) || ((state == IDLE) && match));

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      udp_out_valid      <= 1'b0;
      udp_out_last       <= 1'b0;
      udp_out_src_port   <= 16'd0;
      udp_out_dst_port   <= 16'd0;
      udp_out_ip_address <= 32'd0;
      udp_out_length     <= 16'd0;
      udp_out_data       <= 32'd0;
      udp_out_error      <= 4'd0;
      accept_count       <= 16'd0;
      drop_count         <= 16'd0;
    end else begin
      case (state)
        IDLE: if (src_xfer && !udp_source_last) state <= match ? PASS : DROP;
        PASS: if (src_xfer && udp_source_last) state <= IDLE;
        DROP: if (src_xfer && udp_source_last) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (load) begin
        udp_out_valid      <= 1'b1;
        udp_out_last       <= udp_source_last;
        udp_out_src_port   <= udp_source_src_port;
        udp_out_dst_port   <= udp_source_dst_port;
        udp_out_ip_address <= udp_source_ip_address;
        udp_out_length     <= udp_source_length;
        udp_out_data       <= udp_source_data;
        udp_out_error      <= udp_source_error;
      end else if (out_xfer) begin
        udp_out_valid <= 1'b0;
      end

      // Clear has priority over an increment landing in the same cycle.
      if (stats_clear) begin
        accept_count <= 16'd0;
        drop_count   <= 16'd0;
      end else if (first_xfer) begin
        if (match && (accept_count != 16'hFFFF)) accept_count <= accept_count + 16'd1;
        if (!match && (drop_count != 16'hFFFF))  drop_count   <= drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_udp_port_filter.sv
// Self-checking bench for udp_port_filter: directed packets plus a randomized phase, with a
// scoreboard of expected output beats and a model of the two counters.
module tb_udp_port_filter;
  localparam int W = 117;

  logic        clock = 1'b0;
  logic        reset;
  logic        udp_source_valid, udp_source_last, udp_source_ready;
  logic [15:0] udp_source_src_port, udp_source_dst_port, udp_source_length;
  logic [31:0] udp_source_ip_address, udp_source_data;
  logic [3:0]  udp_source_error;
  logic        udp_out_valid, udp_out_last, udp_out_ready;
  logic [15:0] udp_out_src_port, udp_out_dst_port, udp_out_length;
  logic [31:0] udp_out_ip_address, udp_out_data;
  logic [3:0]  udp_out_error;
  logic        enable, stats_clear;
  logic [15:0] accept_count, drop_count;
  logic [1:0]  fsm_state;

  udp_port_filter dut (
    .clock(clock), .reset(reset),
    .udp_source_valid(udp_source_valid), .udp_source_last(udp_source_last),
    .udp_source_ready(udp_source_ready),
    .udp_source_src_port(udp_source_src_port), .udp_source_dst_port(udp_source_dst_port),
    .udp_source_ip_address(udp_source_ip_address), .udp_source_length(udp_source_length),
    .udp_source_data(udp_source_data), .udp_source_error(udp_source_error),
    .udp_out_valid(udp_out_valid), .udp_out_last(udp_out_last), .udp_out_ready(udp_out_ready),
    .udp_out_src_port(udp_out_src_port), .udp_out_dst_port(udp_out_dst_port),
    .udp_out_ip_address(udp_out_ip_address), .udp_out_length(udp_out_length),
    .udp_out_data(udp_out_data), .udp_out_error(udp_out_error),
    .enable(enable), .stats_clear(stats_clear),
    .accept_count(accept_count), .drop_count(drop_count), .fsm_state(fsm_state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic [W-1:0] exp_q[$];
  int          cyc_q[$];
  bit          check_lat = 1'b1;
  bit          bp = 1'b0;
  logic [15:0] exp_acc, exp_drop;
  logic [15:0] len_tab [5] = '{16'd3, 16'd4, 16'd12, 16'd1472, 16'd1473};

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Scoreboard: every downstream handshake pops one expected beat.
  always @(negedge clock) begin
    if (!reset && udp_out_valid && udp_out_ready) begin
      if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
      else begin
        logic [W-1:0] e;
        int c;
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("out_beat", {udp_out_last, udp_out_data, udp_out_error, udp_out_length,
                           udp_out_dst_port, udp_out_src_port, udp_out_ip_address}, e);
        if (check_lat) check("latency", cyc, c + 1);
      end
    end
  end

  // Random downstream backpressure
  always @(posedge clock) begin
    if (bp) begin
      #1;
      udp_out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Driver: sends `cut` beats of an `nbeats` packet; first-beat fields decide the model outcome.
  task automatic send_pkt(input logic [15:0] dst, input logic [15:0] len, input logic [3:0] err,
                          input bit en, input int nbeats, input int cut, input bit gaps,
                          input bit mid_change, input bit clr);
    bit          match;
    bit          done;
    logic [15:0] sp;
    logic [31:0] ip;
    match = en && (dst == 16'd6000) && (len >= 16'd4) && (len <= 16'd1472) && (err == 4'h0);
    sp = 16'($urandom);
    ip = $urandom;
    for (int i = 0; i < cut; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        udp_source_valid    = 1'b0;
        udp_source_data     = $urandom;
        udp_source_dst_port = 16'($urandom);
        @(posedge clock); #1;
      end
      udp_source_valid      = 1'b1;
      udp_source_last       = (i == nbeats - 1);
      udp_source_dst_port   = (i > 0 && mid_change) ? 16'($urandom) : dst;
      udp_source_length     = len;
      udp_source_error      = (i == 0) ? err : (gaps ? 4'($urandom) : 4'h0);
      udp_source_data       = $urandom;
      udp_source_src_port   = sp;
      udp_source_ip_address = ip;
      if (i == 0) enable = en;
      else if (mid_change) enable = ~en;
      stats_clear = (i == 0) && clr;
      done = 1'b0;
      for (int t = 0; t < 200 && !done; t++) begin
        @(negedge clock);
        if (!match && i > 0) check("drop_ready", udp_source_ready, 1);
        if (udp_source_ready) begin
          done = 1'b1;
          if (match) begin
            exp_q.push_back({udp_source_last, udp_source_data, udp_source_error, udp_source_length,
                             udp_source_dst_port, udp_source_src_port, udp_source_ip_address});
            cyc_q.push_back(cyc);
          end
          if (i == 0) begin
            if (clr) begin
              exp_acc  = 16'd0;
              exp_drop = 16'd0;
            end else if (match) exp_acc = sat_inc(exp_acc);
            else exp_drop = sat_inc(exp_drop);
          end
        end
        @(posedge clock); #1;
      end
      if (!done) check("src_timeout", 0, 1);
      stats_clear = 1'b0;
    end
    udp_source_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    stats_clear = 1'b1;
    @(posedge clock); #1;
    stats_clear = 1'b0;
    exp_acc  = 16'd0;
    exp_drop = 16'd0;
  endtask

  task automatic drain_and_check(input string tag);
    repeat (4) @(posedge clock);
    #1;
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_accept"}, accept_count, exp_acc);
    check({tag, "_drop"}, drop_count, exp_drop);
  endtask

  initial begin
    reset = 1'b1;
    udp_source_valid = 1'b0; udp_source_last = 1'b0;
    udp_source_src_port = '0; udp_source_dst_port = '0; udp_source_ip_address = '0;
    udp_source_length = '0; udp_source_data = '0; udp_source_error = '0;
    udp_out_ready = 1'b1; enable = 1'b1; stats_clear = 1'b0;
    exp_acc = 16'd0; exp_drop = 16'd0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_ready", udp_source_ready, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("reset_ready_after", udp_source_ready, 1);
    check("reset_outputs", {udp_out_valid, udp_out_last, udp_out_data, udp_out_error, udp_out_length,
                            udp_out_dst_port, udp_out_src_port, udp_out_ip_address}, 0);
    check("reset_counts", {accept_count, drop_count}, 0);
    check("reset_state", fsm_state, 0);
    @(posedge clock); #1;

    // Basic matching 3-beat packet
    send_pkt(16'd6000, 16'd12, 4'h0, 1'b1, 3, 3, 1'b0, 1'b0, 1'b0);
    drain_and_check("match3");

    // Wrong port dropped, then a matching packet passes
    send_pkt(16'd6001, 16'd12, 4'h0, 1'b1, 3, 3, 1'b0, 1'b0, 1'b0);
    drain_and_check("drop3");
    send_pkt(16'd6000, 16'd40, 4'h0, 1'b1, 3, 3, 1'b0, 1'b0, 1'b0);
    drain_and_check("after_drop");

    // Backpressure: out_ready low for 5 cycles after the first beat
    check_lat = 1'b0;
    udp_out_ready = 1'b0;
    fork
      send_pkt(16'd6000, 16'd100, 4'h0, 1'b1, 3, 3, 1'b0, 1'b0, 1'b0);
      begin
        logic [31:0] held;
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
          @(negedge clock);
          if (udp_out_valid) seen = 1'b1;
        end
        if (!seen) check("stall_valid_timeout", 0, 1);
        held = udp_out_data;
        check("stall_ready", udp_source_ready, 0);
        for (int k = 1; k < 5; k++) begin
          @(negedge clock);
          check("stall_ready", udp_source_ready, 0);
          check("stall_data", udp_out_data, held);
        end
        @(posedge clock); #1;
        udp_out_ready = 1'b1;
      end
    join
    drain_and_check("stall");
    check_lat = 1'b1;

    // Each filter criterion rejects on its own
    pulse_clear();
    send_pkt(16'd6000, 16'd2,    4'h0, 1'b1, 2, 2, 1'b0, 1'b0, 1'b0);
    send_pkt(16'd6000, 16'd1473, 4'h0, 1'b1, 2, 2, 1'b0, 1'b0, 1'b0);
    send_pkt(16'd6000, 16'd12,   4'h1, 1'b1, 2, 2, 1'b0, 1'b0, 1'b0);
    send_pkt(16'd6000, 16'd12,   4'h0, 1'b0, 2, 2, 1'b0, 1'b0, 1'b0);
    drain_and_check("criteria");
    check("criteria_drop4", drop_count, 16'd4);

    // Boundary lengths, then randomized traffic with gaps and backpressure
    send_pkt(16'd6000, 16'd4,    4'h0, 1'b1, 1, 1, 1'b0, 1'b0, 1'b0);
    send_pkt(16'd6000, 16'd1472, 4'h0, 1'b1, 2, 2, 1'b0, 1'b1, 1'b0);
    drain_and_check("bounds");
    check_lat = 1'b0;
    bp = 1'b1;
    for (int p = 0; p < 30; p++) begin
      int nb;
      nb = $urandom_range(1, 4);
      send_pkt(($urandom_range(0, 2) != 0) ? 16'd6000 : 16'd6001,
               len_tab[$urandom_range(0, 4)],
               ($urandom_range(0, 3) == 0) ? 4'h1 : 4'h0,
               ($urandom_range(0, 4) != 0), nb, nb, 1'b1,
               1'($urandom_range(0, 1)), 1'b0);
    end
    bp = 1'b0;
    @(posedge clock); #2;
    udp_out_ready = 1'b1;
    drain_and_check("random");
    check_lat = 1'b1;

    // Reset in the middle of a PASS packet
    send_pkt(16'd6000, 16'd12, 4'h0, 1'b1, 4, 2, 1'b0, 1'b0, 1'b0);
    check("pre_reset_state", fsm_state, 1);
    @(negedge clock);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("midreset_ready", udp_source_ready, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    exp_acc = 16'd0;
    exp_drop = 16'd0;
    @(negedge clock);
    check("midreset_valid", udp_out_valid, 0);
    check("midreset_state", fsm_state, 0);
    check("midreset_queue", exp_q.size(), 0);
    @(posedge clock); #1;
    send_pkt(16'd6000, 16'd12, 4'h0, 1'b1, 2, 2, 1'b0, 1'b0, 1'b0);
    drain_and_check("after_reset");

    // drop_count saturation and clear priority
    pulse_clear();
    for (int n = 0; n < 65535; n++)
      send_pkt(16'd6001, 16'd12, 4'h0, 1'b1, 1, 1, 1'b0, 1'b0, 1'b0);
    check("sat_full", drop_count, 16'hFFFF);
    send_pkt(16'd6001, 16'd12, 4'h0, 1'b1, 1, 1, 1'b0, 1'b0, 1'b0);
    check("sat_hold", drop_count, 16'hFFFF);
    send_pkt(16'd6001, 16'd12, 4'h0, 1'b1, 1, 1, 1'b0, 1'b0, 1'b1);
    check("clear_wins", drop_count, 16'd0);
    drain_and_check("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
